// File: rtl/spi_flash_rdseq_if.sv
// Interface bundle for spi_flash_rdseq.
// Groups three sets of signals:
//   - the read request handshake (req_*)
//   - the received-byte stream (data, data_valid, data_ready) and busy
//   - the SB_SPI system bus (sb_*)
// The slave modport is the sequencer's view.
// The master modport is the environment's view: requester, consumer and SB_SPI core.
interface spi_flash_rdseq_if #(
  parameter int unsigned LEN_W = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [23:0]      req_addr;
  logic [LEN_W-1:0] req_len;
  logic [7:0]       data;
  logic             data_valid;
  logic             data_ready;
  logic             busy;
  logic [7:0]       sb_addr;
  logic [7:0]       sb_di;
  logic             sb_rw;
  logic             sb_stb;
  logic [7:0]       sb_do;
  logic             sb_ack;

  modport slave (
    input  req_valid, req_addr, req_len, data_ready, sb_do, sb_ack,
    output req_ready, data, data_valid, busy, sb_addr, sb_di, sb_rw, sb_stb
  );

  modport master (
    output req_valid, req_addr, req_len, data_ready, sb_do, sb_ack,
    input  req_ready, data, data_valid, busy, sb_addr, sb_di, sb_rw, sb_stb
  );
endinterface

// File: rtl/spi_flash_rdseq.sv
// spi_flash_rdseq: owns the iCE40 SB_SPI system bus and runs SPI flash READ (0x03)
// transfers without CPU involvement.
//
// Behaviour:
//   - After reset it initialises the SPI core once.
//   - It then accepts one read request at a time.
//   - Received bytes are streamed out with backpressure.
//
// Ports:
//   clk    24 MHz SoC clock
//   rst_n  asynchronous active-low reset
//   bus    spi_flash_rdseq_if.slave, carrying:
//            - request:    req_valid/req_ready/req_addr/req_len
//                          (req_len is the byte count minus one)
//            - byte out:   data/data_valid/data_ready, plus busy
//            - SB_SPI bus: sb_addr/sb_di/sb_rw/sb_stb out, sb_do/sb_ack in
//
// State table
//   state      | meaning
//   INIT_CSR   | init: write CSR=0x0F (release all chip selects)
//   INIT_CR1   | init: write CR1=0x80 (enable core)
//   INIT_CR2   | init: write CR2=0xC0 (master, manual CS hold)
//   INIT_BR    | init: write BR=SPI_BR
//   IDLE       | ready for a request
//   CS_LO      | write CSR=0x0E (assert CS0)
//   POLL_T     | read SR until TRDY
//   WR         | write TXDR (command/address byte or 0x00 dummy)
//   POLL_R     | read SR until RRDY
//   RD         | read RXDR (discarded during the command phase)
//   OUT        | data byte presented, waiting for data_ready
//   CS_HI      | write CSR=0x0F (release CS0), then back to IDLE
module spi_flash_rdseq #(
  parameter int unsigned LEN_W  = 16,
  parameter logic [7:0]  SPI_BR = 8'h00
) (
  input logic              clk,
  input logic              rst_n,
  spi_flash_rdseq_if.slave bus
);

  localparam logic [7:0] A_CR1  = 8'h09;
  localparam logic [7:0] A_CR2  = 8'h0A;
  localparam logic [7:0] A_BR   = 8'h0B;
  localparam logic [7:0] A_SR   = 8'h0C;
  localparam logic [7:0] A_TXDR = 8'h0D;
  localparam logic [7:0] A_RXDR = 8'h0E;
  localparam logic [7:0] A_CSR  = 8'h0F;

  typedef enum logic [3:0] {
    S_INIT_CSR, S_INIT_CR1, S_INIT_CR2, S_INIT_BR, S_IDLE, S_CS_LO,
    S_POLL_T, S_WR, S_POLL_R, S_RD, S_OUT, S_CS_HI
  } state_t;

  state_t           state, state_nxt;
  logic             gap;
  logic [23:0]      addr_q;
  logic [LEN_W-1:0] cnt_q;
  logic [2:0]       byte_idx;
  logic [7:0]       data_q;

  logic             acc_req, acc_rw;
  logic [7:0]       acc_addr, acc_di, tx_byte;
  logic             stb, acc_done, data_phase;

  // gap forces the strobe low for one cycle after every ack, and for the first
  // cycle after reset, so back-to-back accesses never merge.
  assign stb        = acc_req & ~gap;
  assign acc_done   = stb & bus.sb_ack;
  assign data_phase = (byte_idx == 3'd4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT_CSR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT_CSR: if (acc_done) state_nxt = S_INIT_CR1;
      S_INIT_CR1: if (acc_done) state_nxt = S_INIT_CR2;
      S_INIT_CR2: if (acc_done) state_nxt = S_INIT_BR;
      S_INIT_BR:  if (acc_done) state_nxt = S_IDLE;
      S_IDLE:     if (bus.req_valid) state_nxt = S_CS_LO;
      S_CS_LO:    if (acc_done) state_nxt = S_POLL_T;
      S_POLL_T:   if (acc_done && bus.sb_do[4]) state_nxt = S_WR;
      S_WR:       if (acc_done) state_nxt = S_POLL_R;
      S_POLL_R:   if (acc_done && bus.sb_do[3]) state_nxt = S_RD;
      S_RD:       if (acc_done) state_nxt = data_phase ? S_OUT : S_POLL_T;
      S_OUT:      if (bus.data_ready) state_nxt = (cnt_q == '0) ? S_CS_HI : S_POLL_T;
      S_CS_HI:    if (acc_done) state_nxt = S_IDLE;
      default:    state_nxt = S_INIT_CSR;
    endcase
  end

  always_comb begin
    acc_req  = 1'b0;
    acc_rw   = 1'b0;
    acc_addr = 8'h00;
    acc_di   = 8'h00;
    case (state)
      S_INIT_CSR: begin acc_req = 1'b1; acc_rw = 1'b1; acc_addr = A_CSR;  acc_di = 8'h0F;  end
      S_INIT_CR1: begin acc_req = 1'b1; acc_rw = 1'b1; acc_addr = A_CR1;  acc_di = 8'h80;  end
      S_INIT_CR2: begin acc_req = 1'b1; acc_rw = 1'b1; acc_addr = A_CR2;  acc_di = 8'hC0;  end
      S_INIT_BR:  begin acc_req = 1'b1; acc_rw = 1'b1; acc_addr = A_BR;   acc_di = SPI_BR; end
      S_CS_LO:    begin acc_req = 1'b1; acc_rw = 1'b1; acc_addr = A_CSR;  acc_di = 8'h0E;  end
      S_POLL_T:   begin acc_req = 1'b1; acc_addr = A_SR; end
      S_WR:       begin acc_req = 1'b1; acc_rw = 1'b1; acc_addr = A_TXDR; acc_di = tx_byte; end
      S_POLL_R:   begin acc_req = 1'b1; acc_addr = A_SR; end
      S_RD:       begin acc_req = 1'b1; acc_addr = A_RXDR; end
      S_CS_HI:    begin acc_req = 1'b1; acc_rw = 1'b1; acc_addr = A_CSR;  acc_di = 8'h0F;  end
      default:    ;
    endcase
  end

  always_comb begin
    case (byte_idx)
      3'd0:    tx_byte = 8'h03;
      3'd1:    tx_byte = addr_q[23:16];
      3'd2:    tx_byte = addr_q[15:8];
      3'd3:    tx_byte = addr_q[7:0];
      default: tx_byte = 8'h00;
    endcase
  end

  // byte_idx walks 0..3 through the command bytes and then parks at 4 for every data byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap      <= 1'b1;
      addr_q   <= '0;
      cnt_q    <= '0;
      byte_idx <= '0;
      data_q   <= '0;
    end else begin
      gap <= acc_done;
      if (state == S_IDLE && bus.req_valid) begin
        addr_q <= bus.req_addr;
        cnt_q  <= bus.req_len;
      end
      if (state == S_CS_LO && acc_done) byte_idx <= '0;
      if (state == S_RD && acc_done) begin
        if (data_phase) data_q <= bus.sb_do;
        else            byte_idx <= byte_idx + 3'd1;
      end
      if (state == S_OUT && bus.data_ready && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Address/data/rw are zeroed outside a strobe so the bus idles at its reset values.
  assign bus.sb_stb     = stb;
  assign bus.sb_rw      = stb & acc_rw;
  assign bus.sb_addr    = stb ? acc_addr : 8'h00;
  assign bus.sb_di      = stb ? acc_di : 8'h00;
  assign bus.req_ready  = (state == S_IDLE);
  assign bus.busy       = (state != S_IDLE);
  assign bus.data_valid = (state == S_OUT);
  assign bus.data       = data_q;

endmodule

// File: tb/tb_spi_flash_rdseq.sv
module tb_spi_flash_rdseq;
  localparam int LW = 4;
  localparam logic [7:0] BR = 8'h5A;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_flash_rdseq_if #(.LEN_W(LW)) bus ();
  spi_flash_rdseq #(.LEN_W(LW), .SPI_BR(BR)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {logic [7:0] a; logic rw; logic [7:0] d;} acc_t;
  typedef struct {
    logic [23:0] addr; logic [LW-1:0] len; int th; int rh; int lat;
    int stall_idx; int stall_len; bit rnd; logic [7:0] exp_first; string name;
  } vec_t;

  int n_chk = 0, n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Flash contents: 0xA0 at 0x123456, incrementing with address.
  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    logic [23:0] d;
    d = a - 24'h123456;
    return d[7:0] + 8'hA0;
  endfunction

  // ---------------- SB_SPI + flash behavioural model ----------------
  int t_hold = 0, r_hold = 0, ack_lat = 0, wcnt = 0;
  int m_phase = 0, m_polls = 0, m_byte = 0, viol = 0;
  logic [23:0] m_addr = '0;
  acc_t log_q[$], exp_q[$];
  logic [7:0] do_v;

  assign bus.sb_ack = bus.sb_stb && (wcnt >= ack_lat);
  assign bus.sb_do  = do_v;

  always_comb begin
    do_v = 8'h00;
    if (bus.sb_addr == 8'h0C) begin
      if (m_phase == 0 && m_polls >= t_hold) do_v = 8'h10;
      if (m_phase == 1) do_v = (m_polls >= r_hold) ? 8'h88 : 8'h80;
    end else if (bus.sb_addr == 8'h0E) begin
      do_v = (m_byte < 4) ? 8'hFF : flash_byte(m_addr + 24'(m_byte - 4));
    end
  end

  always @(posedge clk) begin
    if (bus.sb_stb && !bus.sb_ack) wcnt <= wcnt + 1;
    else                           wcnt <= 0;
    if (bus.sb_stb && bus.sb_ack) begin
      log_q.push_back(acc_t'({bus.sb_addr, bus.sb_rw, bus.sb_di}));
      case (bus.sb_addr)
        8'h0F: if (bus.sb_rw) begin m_phase <= 0; m_polls <= 0; m_byte <= 0; end
        8'h0C: m_polls <= m_polls + 1;
        8'h0D: begin
          if (m_phase != 0 || m_polls <= t_hold) viol <= viol + 1;
          m_phase <= 1; m_polls <= 0;
          if (m_byte == 1) m_addr[23:16] <= bus.sb_di;
          if (m_byte == 2) m_addr[15:8]  <= bus.sb_di;
          if (m_byte == 3) m_addr[7:0]   <= bus.sb_di;
        end
        8'h0E: begin
          if (m_phase != 1 || m_polls <= r_hold) viol <= viol + 1;
          m_phase <= 0; m_polls <= 0; m_byte <= m_byte + 1;
        end
        default: ;
      endcase
    end
  end

  // Bus protocol monitor: hold-until-ack, one idle cycle after ack, data_valid after RXDR data read.
  int stab_err = 0, gap_err = 0, dv_err = 0;
  logic pend = 1'b0, last_ack = 1'b0, exp_dv = 1'b0;
  logic [16:0] pend_v = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pend <= 1'b0; last_ack <= 1'b0; exp_dv <= 1'b0;
    end else begin
      if (exp_dv && !bus.data_valid) dv_err <= dv_err + 1;
      if (bus.sb_stb && pend && {bus.sb_addr, bus.sb_rw, bus.sb_di} != pend_v) stab_err <= stab_err + 1;
      if (last_ack && bus.sb_stb) gap_err <= gap_err + 1;
      pend     <= bus.sb_stb && !bus.sb_ack;
      pend_v   <= {bus.sb_addr, bus.sb_rw, bus.sb_di};
      last_ack <= bus.sb_stb && bus.sb_ack;
      exp_dv   <= bus.sb_stb && bus.sb_ack && bus.sb_addr == 8'h0E && m_byte >= 4;
    end
  end

  // ---------------- expected access sequence (transaction level) ----------------
  task automatic exp_wr(input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back(acc_t'({a, 1'b1, d}));
  endtask
  task automatic exp_rd(input logic [7:0] a);
    exp_q.push_back(acc_t'({a, 1'b0, 8'h00}));
  endtask
  task automatic exp_byte(input logic [7:0] tx, input int th, input int rh);
    repeat (th + 1) exp_rd(8'h0C);
    exp_wr(8'h0D, tx);
    repeat (rh + 1) exp_rd(8'h0C);
    exp_rd(8'h0E);
  endtask
  task automatic exp_req(input logic [23:0] addr, input int len, input int th, input int rh);
    exp_wr(8'h0F, 8'h0E);
    exp_byte(8'h03, th, rh);
    exp_byte(addr[23:16], th, rh);
    exp_byte(addr[15:8], th, rh);
    exp_byte(addr[7:0], th, rh);
    for (int k = 0; k <= len; k++) exp_byte(8'h00, th, rh);
    exp_wr(8'h0F, 8'h0F);
  endtask

  function automatic int count_tx();
    int c = 0;
    foreach (log_q[i]) if (log_q[i].a == 8'h0D && log_q[i].rw) c++;
    return c;
  endfunction

  task automatic compare_log(input string name);
    int n;
    check({name, " access count"}, log_q.size(), exp_q.size());
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (exp_q[i].rw) check({name, " write"}, log_q[i], exp_q[i]);
      else check({name, " read"}, {log_q[i].a, log_q[i].rw}, {exp_q[i].a, exp_q[i].rw});
    end
  endtask

  task automatic check_reset_vals(input string name);
    check({name, " sb_stb"}, bus.sb_stb, 0);
    check({name, " sb_rw"}, bus.sb_rw, 0);
    check({name, " sb_addr"}, bus.sb_addr, 0);
    check({name, " sb_di"}, bus.sb_di, 0);
    check({name, " req_ready"}, bus.req_ready, 0);
    check({name, " data_valid"}, bus.data_valid, 0);
    check({name, " data"}, bus.data, 0);
    check({name, " busy"}, bus.busy, 1);
  endtask

  // Called at a negedge with rst_n low.
  task automatic release_init(input string name);
    acc_t ie[4];
    int n;
    ie[0] = acc_t'({8'h0F, 1'b1, 8'h0F});
    ie[1] = acc_t'({8'h09, 1'b1, 8'h80});
    ie[2] = acc_t'({8'h0A, 1'b1, 8'hC0});
    ie[3] = acc_t'({8'h0B, 1'b1, BR});
    log_q.delete();
    rst_n = 1'b1;
    repeat (7) @(negedge clk);
    check({name, " ready early"}, bus.req_ready, 0);
    @(negedge clk);
    check({name, " ready at 8"}, bus.req_ready, 1);
    check({name, " busy after init"}, bus.busy, 0);
    check({name, " init access count"}, log_q.size(), 4);
    n = (log_q.size() < 4) ? log_q.size() : 4;
    for (int i = 0; i < n; i++) check({name, " init write"}, log_q[i], ie[i]);
  endtask

  task automatic send_req(input logic [23:0] addr, input logic [LW-1:0] len);
    int n = 0;
    while (!bus.req_ready && n < 200) begin @(negedge clk); n++; end
    check("ready before request", bus.req_ready, 1);
    bus.req_addr = addr; bus.req_len = len; bus.req_valid = 1'b1;
    @(negedge clk);
    check("ready drops after accept", bus.req_ready, 0);
    check("busy after accept", bus.busy, 1);
  endtask

  task automatic run_req(input vec_t v);
    logic [7:0] got[$];
    logic [7:0] held;
    int cyc, stall_left, tx0, s0, g0, d0, v0;
    bit hs_prev, rdy;
    t_hold = v.th; r_hold = v.rh; ack_lat = v.lat;
    @(negedge clk);
    log_q.delete(); exp_q.delete();
    exp_req(v.addr, int'(v.len), v.th, v.rh);
    s0 = stab_err; g0 = gap_err; d0 = dv_err; v0 = viol;
    held = '0; tx0 = 0; hs_prev = 0;
    send_req(v.addr, v.len);
    bus.req_addr = ~v.addr;
    repeat (4) begin
      @(negedge clk);
      check({v.name, " ready while busy"}, bus.req_ready, 0);
    end
    bus.req_valid = 1'b0;
    cyc = 0; stall_left = v.stall_len;
    while (bus.busy && cyc < 20000) begin
      if (hs_prev) check({v.name, " data_valid drop"}, bus.data_valid, 0);
      hs_prev = 0;
      if (bus.data_valid && got.size() == v.stall_idx && stall_left > 0) begin
        if (stall_left == v.stall_len) begin held = bus.data; tx0 = count_tx(); end
        else check({v.name, " stall data"}, bus.data, held);
        bus.data_ready = 1'b0;
        stall_left--;
        if (stall_left == 0) check({v.name, " no TXDR in stall"}, count_tx(), tx0);
      end else begin
        rdy = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.data_ready = rdy;
        if (rdy && bus.data_valid) begin got.push_back(bus.data); hs_prev = 1; end
      end
      @(negedge clk);
      cyc++;
    end
    bus.data_ready = 1'b0;
    check({v.name, " transfer done"}, bus.busy, 0);
    check({v.name, " ready at end"}, bus.req_ready, 1);
    check({v.name, " byte count"}, got.size(), int'(v.len) + 1);
    if (got.size() > 0) check({v.name, " first byte"}, got[0], v.exp_first);
    foreach (got[k]) check({v.name, " data byte"}, got[k], flash_byte(v.addr + 24'(k)));
    compare_log(v.name);
    check({v.name, " ready-bit order"}, viol - v0, 0);
    check({v.name, " bus hold"}, stab_err - s0, 0);
    check({v.name, " strobe gap"}, gap_err - g0, 0);
    check({v.name, " data_valid timing"}, dv_err - d0, 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    vec_t rv;
    logic [31:0] r;
    int n;
    bit hs;

    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_len = '0; bus.data_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    release_init("init");

    tbl[0] = '{24'h123456, 4'd3,  0, 0, 0, -1, 0,  1'b0, 8'hA0, "basic"};
    tbl[1] = '{24'h123456, 4'd3,  0, 0, 0,  2, 20, 1'b0, 8'hA0, "stall"};
    tbl[2] = '{24'h123456, 4'd3,  5, 3, 0, -1, 0,  1'b0, 8'hA0, "slow sr"};
    tbl[3] = '{24'h123456, 4'd3,  0, 0, 3, -1, 0,  1'b0, 8'hA0, "ack3"};
    tbl[4] = '{24'h12345A, 4'd15, 0, 0, 1, -1, 0,  1'b1, 8'hA4, "max len"};
    tbl[5] = '{24'hFFFFFF, 4'd0,  1, 0, 0, -1, 0,  1'b0, 8'h49, "single"};
    for (int i = 0; i < 6; i++) run_req(tbl[i]);

    for (int i = 0; i < 8; i++) begin
      r = $urandom();
      rv.addr = r[23:0];
      rv.len = LW'($urandom_range(0, 5));
      rv.th = $urandom_range(0, 3);
      rv.rh = $urandom_range(0, 3);
      rv.lat = $urandom_range(0, 2);
      rv.stall_idx = -1; rv.stall_len = 0; rv.rnd = 1'b1;
      rv.exp_first = flash_byte(rv.addr);
      rv.name = "random";
      run_req(rv);
    end

    // Reset pulse during the engine run for data byte 1.
    t_hold = 0; r_hold = 0; ack_lat = 0;
    send_req(24'h123456, 4'd3);
    bus.req_valid = 1'b0;
    bus.data_ready = 1'b1;
    n = 0; hs = 0;
    while (!hs && n < 500) begin
      if (bus.data_valid) hs = 1;
      @(negedge clk);
      n++;
    end
    check("byte0 before reset", hs, 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("mid reset");
    bus.data_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    release_init("post reset");
    run_req(tbl[0]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/spi_flash_rdseq.md
# spi_flash_rdseq

Hardware sequencer that owns the iCE40 `SB_SPI` hard-IP system bus and performs SPI flash READ (0x03) transfers without CPU involvement. It runs a one-time init of the SPI core, then serves single-requester read commands and streams the received bytes out with backpressure. It sits between a requester (e.g. a DMA engine feeding SPRAM) and `SB_SPI`, replacing per-byte CPU register polling. It runs in the 24 MHz SoC domain.

## Interface
- `LEN_W`, 16: width of `req_len`.
- `SPI_BR`, 8'h00: value written to SPIBR (SCK divider).
- `clk`  in  1: SoC clock (24 MHz domain).
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  1: read request.
- `req_ready`  out  1: request accepted when `req_valid & req_ready`.
- `req_addr`  in  24: flash byte address.
- `req_len`  in  LEN_W: byte count minus one.
- `data`  out  8: received flash byte.
- `data_valid`  out  1: `data` valid; held until `data_ready`.
- `data_ready`  in  1: consumer accepts the byte.
- `busy`  out  1: high from reset until init is done, and while a request is in flight.
- `sb_addr`  out  8: SB_SPI register address.
- `sb_di`  out  8: SB_SPI write data.
- `sb_rw`  out  1: 1 = write.
- `sb_stb`  out  1: bus strobe.
- `sb_do`  in  8: SB_SPI read data.
- `sb_ack`  in  1: SB_SPI acknowledge.

## Operation
- Register map (BUS_ADDR74 = 0): CR1 = 0x09, CR2 = 0x0A, BR = 0x0B, SR = 0x0C, TXDR = 0x0D, RXDR = 0x0E, CSR = 0x0F. SR bit 4 = TRDY, SR bit 3 = RRDY.
- Bus access: drive `sb_addr`/`sb_rw`/`sb_di` with `sb_stb=1`, and hold them stable until `sb_ack`. Read data is sampled from `sb_do` in the ack cycle. `sb_stb` is low for at least 1 cycle between accesses.
- **Init** (once after reset), in order:
  - write CSR = 0x0F (release all CS);
  - write CR1 = 0x80 (enable);
  - write CR2 = 0xC0 (master, manual CS hold);
  - write BR = `SPI_BR`;
  - then go to IDLE.
- **IDLE**: `req_ready=1`. On accept:
  - latch `req_addr` and `req_len` into a remaining-byte counter;
  - write CSR = 0x0E (CS0 low).
- **Byte engine** (used for each byte):
  - POLL_T: read SR until TRDY = 1;
  - WR: write TXDR;
  - POLL_R: read SR until RRDY = 1;
  - RD: read RXDR.
- **Command phase**: send 4 bytes through the byte engine: 0x03, addr[23:16], addr[15:8], addr[7:0]. Their RXDR reads are discarded.
- **Data phase**: send 0x00 through the byte engine. The RXDR value is loaded into `data` and `data_valid` is raised. The next byte's TX does not start until the handshake completes (SCK stalls; this is legal for flash).
- **End of transfer**: after the data byte with counter = 0 is handshaken, write CSR = 0x0F, then return to IDLE.
- Counter decrements on each data handshake. Total bytes = `req_len`+1. `req_len` = all-ones gives 2^LEN_W bytes, and the counter does not wrap early.
- `req_valid` while not in IDLE: ignored, and `req_ready` stays 0.
- Reset mid-transfer: all state and outputs return to reset values immediately; the SB_SPI core is not reset. Init rewrites CSR first, so CS is released before any new command.

## Timing
- Reset values: `sb_stb=0`, `sb_rw=0`, `sb_addr=0`, `sb_di=0`, `req_ready=0`, `data_valid=0`, `data=0`, `busy=1`.
- With zero-latency ack (`sb_ack=sb_stb`), each access takes 2 cycles (strobe + gap).
  - Init = 8 cycles; `req_ready` rises on the cycle after the last init ack.
  - The minimum per-byte cost is 4 accesses.
- `req_ready` drops the cycle after accept. `busy` rises in the same cycle.
- `data_valid` rises the cycle after the RXDR ack and falls the cycle after the handshake.
- `busy` falls the cycle after the final CSR write acks, coincident with `req_ready` rising.

## Test plan
- Reset release with zero-latency ack model:
  - writes seen in order: 0x0F←0x0F, 0x09←0x80, 0x0A←0xC0, 0x0B←`SPI_BR`;
  - `req_ready=1` exactly 8 cycles after reset release.
- Request addr 0x123456, len 3, flash model returns 0xA0..0xA3:
  - TXDR writes: 03, 12, 34, 56, 00, 00, 00, 00;
  - output bytes A0, A1, A2, A3;
  - CSR writes 0x0E before and 0x0F after.
- Same request with `data_ready` low for 20 cycles on byte 2:
  - `data`=A2 held stable throughout;
  - no TXDR write occurs during the stall.
- SR model holding TRDY=0 for 5 polls and RRDY=0 for 3 polls: exactly 5 and 3 extra SR reads are issued, with no TXDR/RXDR access before the respective ready bit.
- `sb_ack` delayed 3 cycles on every access: `sb_addr`/`sb_di`/`sb_rw` stable for the full strobe, and the outputs match the first data scenario.
- `rst_n` pulsed low during the data phase of byte 1:
  - all outputs at reset values asynchronously;
  - the first access after release is CSR←0x0F.
